pipe_hazard_ctrl: RTL

Pipeline hazard controller for the five-stage core. It generates the stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers and for the PC. It resolves three hazards:
- load-use data hazards, with a one-bubble insert;
- taken branches and jumps resolved in EX, with a two-slot flush;
- multi-cycle data-memory accesses, with a full freeze through a handshake FSM and a watchdog.

It also keeps stall and flush event counters for debug.

---
 rtl/pipe_ctrl_pkg.sv | 53 +++++
 rtl/hazard_cnt.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// hazard priority enum and the stall/flush control bundle.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Winning hazard for the current cycle, also usable as a debug trace tag
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_LOAD_USE = 2'd1,
    HZ_REDIRECT = 2'd2,
    HZ_FREEZE   = 2'd3
  } hz_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctl_t;

  function automatic pipe_ctl_t hz_decode(input hz_e hz);
    pipe_ctl_t c;
    c = '0;
    case (hz)
      HZ_FREEZE: begin
        c.stall_pc     = 1'b1;
        c.stall_if_id  = 1'b1;
        c.stall_id_ex  = 1'b1;
        c.stall_ex_mem = 1'b1;
      end
      HZ_REDIRECT: begin
        c.flush_if_id = 1'b1;
        c.flush_id_ex = 1'b1;
      end
      HZ_LOAD_USE: begin
        c.stall_pc    = 1'b1;
        c.stall_if_id = 1'b1;
        c.flush_id_ex = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_cnt.sv
// Wrapping event counter with enable and synchronous clear.
module hazard_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generation for load-use, EX redirects and multi-cycle data
// memory accesses, with a freeze watchdog and debug event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_wR,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             mem_wait,
  output logic             wdog_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              wdog_set;
  logic              freeze;
  logic              load_use;
  hz_e               hz_sel;
  pipe_ctl_t         ctl;

  assign load_use = ex_mem_read && (ex_wR != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_wR)) ||
                     (id_rs2_used && (id_rs2 == ex_wR)));

  // State, wait counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      wdog_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (wdog_set) begin
        wdog_err <= 1'b1;
      end
    end
  end

  // Next state, freeze/watchdog decision and prioritised hazard selection
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wdog_set   = 1'b0;
    freeze     = 1'b0;
    hz_sel     = HZ_NONE;

    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        // A dropped mem_req without mem_ready still counts as waiting
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wdog_set = 1'b1;
          state_d  = ST_RUN;
        end else begin
          freeze = 1'b1;
        end
      end
    endcase

    if (rst) begin
      hz_sel = HZ_NONE;
    end else if (freeze) begin
      hz_sel = HZ_FREEZE;
    end else if (ex_redirect) begin
      hz_sel = HZ_REDIRECT;
    end else if (load_use) begin
      hz_sel = HZ_LOAD_USE;
    end

    ctl = hz_decode(hz_sel);
  end

  assign stall_pc     = ctl.stall_pc;
  assign stall_if_id  = ctl.stall_if_id;
  assign stall_id_ex  = ctl.stall_id_ex;
  assign stall_ex_mem = ctl.stall_ex_mem;
  assign flush_if_id  = ctl.flush_if_id;
  assign flush_id_ex  = ctl.flush_id_ex;
  assign mem_wait     = (state_q == ST_MEM_WAIT) && !rst;

  hazard_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (ctl.stall_pc),
    .cnt (stall_cnt)
  );

  hazard_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .en  (ctl.flush_if_id),
    .cnt (flush_cnt)
  );

endmodule
